spi_slave_if: RTL and testbench

SPI mode-0 slave (responder) interface: the far-end counterpart of the team's SPI master, built from the same registered-flop style on a single system clock. It oversamples SCK, SS_N and MOSI in the CLK domain, deserialises MOSI into parallel receive words, and serialises a buffered transmit word onto MISO. It sits between the external SPI pins and the local register/control logic.

---
 rtl/spi_slave_if_if.sv | 28 ++
 rtl/spi_slave_if.sv | 139 +++++++++++++
 tb/tb_spi_slave_if.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if_if.sv
// Signal bundle between an SPI mode-0 slave and its surroundings:
// the serial pins plus the local transmit/receive handshake.
interface spi_slave_if_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sck;
  logic                  ss_n;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_load;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_read;
  logic                  busy;
  logic                  overrun;

  modport slave (
    input  sck, ss_n, mosi, tx_data, tx_load, rx_read,
    output miso, tx_ready, rx_data, rx_valid, busy, overrun
  );

  modport master (
    output sck, ss_n, mosi, tx_data, tx_load, rx_read,
    input  miso, tx_ready, rx_data, rx_valid, busy, overrun
  );
endinterface

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: oversamples SCK/SS_N/MOSI on clk, deserialises MOSI into
// receive words and shifts a buffered transmit word out on MISO.
module spi_slave_if #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           clr_n,
  spi_slave_if_if.slave  bus
);
  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_DESEL} state_t;

  state_t                state_q, state_d;
  logic [2:0]            sck_sync_q, sck_sync_d;
  logic [2:0]            ss_sync_q, ss_sync_d;
  logic [1:0]            mosi_sync_q, mosi_sync_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  overrun_q, overrun_d;

  logic                  sck_rise, sck_fall, sel, desel;
  logic [DATA_WIDTH-1:0] rx_word;
  logic [DATA_WIDTH-1:0] tx_next;

  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
  assign sel      = ~ss_sync_q[1] & ss_sync_q[2];
  assign desel    = ss_sync_q[1] & ~ss_sync_q[2];
  assign rx_word  = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync_q[1]};
  assign tx_next  = tx_ready_q ? '0 : tx_buf_q;

  // SS_N synchroniser resets to "selected" and the FSM to WAIT_DESEL, so a
  // frame cut by reset is ignored until the master releases SS_N.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= WAIT_DESEL;
      sck_sync_q  <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      tx_shift_q  <= '0;
      tx_buf_q    <= '0;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b1;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      tx_shift_q  <= tx_shift_d;
      tx_buf_q    <= tx_buf_d;
      rx_valid_q  <= rx_valid_d;
      tx_ready_q  <= tx_ready_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sck_sync_d  = {sck_sync_q[1:0], bus.sck};
    ss_sync_d   = {ss_sync_q[1:0], bus.ss_n};
    mosi_sync_d = {mosi_sync_q[0], bus.mosi};
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    tx_shift_d  = tx_shift_q;
    tx_buf_d    = tx_buf_q;
    rx_valid_d  = rx_valid_q;
    tx_ready_d  = tx_ready_q;
    overrun_d   = overrun_q;

    if (bus.rx_read) rx_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (sel) begin
          state_d    = ACTIVE;
          tx_shift_d = tx_next;
          tx_ready_d = 1'b1;
        end
      end
      ACTIVE: begin
        if (desel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sck_rise) begin
          rx_shift_d = rx_word;
          if (cnt_q == LAST) begin
            cnt_d      = '0;
            rx_data_d  = rx_word;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !bus.rx_read) overrun_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (sck_fall) begin
          if (cnt_q == '0) begin
            tx_shift_d = tx_next;
            tx_ready_d = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      WAIT_DESEL: begin
        cnt_d = '0;
        if (ss_sync_q[1]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A load in the same cycle as a transfer lands after the old word moved out.
    if (bus.tx_load && tx_ready_q) begin
      tx_buf_d   = bus.tx_data;
      tx_ready_d = 1'b0;
    end
  end

  assign bus.miso     = (state_q == ACTIVE) ? tx_shift_q[DATA_WIDTH-1] : 1'b0;
  assign bus.busy     = (state_q == ACTIVE);
  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: acts as SPI master, scoreboards received
// words and MISO words against expectations queued when stimulus is driven.
module tb_spi_slave_if;
  localparam int HALF = 6;

  logic clk;
  logic clr_n;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] miso_q[$];

  spi_slave_if_if #(.DATA_WIDTH(8)) bus ();

  spi_slave_if #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, ".miso"},     32'(bus.miso),     32'd0);
    check_output({tag, ".tx_ready"}, 32'(bus.tx_ready), 32'd1);
    check_output({tag, ".rx_data"},  32'(bus.rx_data),  32'd0);
    check_output({tag, ".rx_valid"}, 32'(bus.rx_valid), 32'd0);
    check_output({tag, ".busy"},     32'(bus.busy),     32'd0);
    check_output({tag, ".overrun"},  32'(bus.overrun),  32'd0);
  endtask

  task automatic tx_load(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data = d;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
  endtask

  task automatic rx_read();
    @(negedge clk);
    bus.rx_read = 1'b1;
    @(negedge clk);
    bus.rx_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic select();
    @(negedge clk);
    bus.ss_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic deselect();
    bus.ss_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Mode 0: MOSI set while SCK low, MISO captured just before SCK rises.
  task automatic spi_bits(input logic [7:0] w, input int n, output logic [7:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      bus.mosi = w[7-i];
      repeat (HALF) @(negedge clk);
      cap[7-i] = bus.miso;
      bus.sck  = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sck  = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic apply_stimulus(input string tag, input logic [7:0] mosi_w, input logic [7:0] exp_miso);
    logic [7:0] cap;
    rx_q.push_back(mosi_w);
    miso_q.push_back(exp_miso);
    spi_bits(mosi_w, 8, cap);
    check_output({tag, ".miso_word"}, 32'(cap), 32'(miso_q.pop_front()));
    check_output({tag, ".rx_data"},   32'(bus.rx_data), 32'(rx_q.pop_front()));
    check_output({tag, ".rx_valid"},  32'(bus.rx_valid), 32'd1);
  endtask

  initial begin
    logic [7:0] dummy;
    clr_n       = 1'b0;
    bus.sck     = 1'b0;
    bus.ss_n    = 1'b1;
    bus.mosi    = 1'b0;
    bus.tx_data = '0;
    bus.tx_load = 1'b0;
    bus.rx_read = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    clr_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] single word frame");
    tx_load(8'hA5);
    check_output("t1.tx_ready_loaded", 32'(bus.tx_ready), 32'd0);
    select();
    check_output("t1.busy", 32'(bus.busy), 32'd1);
    check_output("t1.tx_ready_sel", 32'(bus.tx_ready), 32'd1);
    apply_stimulus("t1", 8'h3C, 8'hA5);
    deselect();
    check_output("t1.busy_end", 32'(bus.busy), 32'd0);
    rx_read();
    check_output("t1.rx_valid_read", 32'(bus.rx_valid), 32'd0);

    $display("[TB] two words with reads");
    tx_load(8'hFF);
    select();
    apply_stimulus("t2a", 8'h01, 8'hFF);
    rx_read();
    check_output("t2.rx_valid_read", 32'(bus.rx_valid), 32'd0);
    apply_stimulus("t2b", 8'h80, 8'h00);
    rx_read();
    deselect();
    check_output("t2.overrun", 32'(bus.overrun), 32'd0);

    $display("[TB] overrun");
    select();
    apply_stimulus("t3a", 8'h11, 8'h00);
    apply_stimulus("t3b", 8'h22, 8'h00);
    deselect();
    check_output("t3.overrun", 32'(bus.overrun), 32'd1);
    rx_read();
    check_output("t3.rx_valid_read", 32'(bus.rx_valid), 32'd0);
    check_output("t3.overrun_sticky", 32'(bus.overrun), 32'd1);

    $display("[TB] partial word");
    select();
    spi_bits(8'hFF, 5, dummy);
    deselect();
    check_output("t4.partial_valid", 32'(bus.rx_valid), 32'd0);
    select();
    apply_stimulus("t4", 8'h96, 8'h00);
    deselect();

    $display("[TB] reset mid frame");
    rx_read();
    select();
    spi_bits(8'hF0, 3, dummy);
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    check_reset_values("t5.reset");
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    spi_bits(8'hFF, 5, dummy);
    spi_bits(8'h55, 8, dummy);
    check_output("t5.cut_valid", 32'(bus.rx_valid), 32'd0);
    check_output("t5.cut_busy", 32'(bus.busy), 32'd0);
    deselect();
    select();
    apply_stimulus("t5", 8'h69, 8'h00);
    deselect();

    $display("[TB] ignored load");
    rx_read();
    tx_load(8'hC3);
    tx_load(8'h3C);
    check_output("t6.tx_ready", 32'(bus.tx_ready), 32'd0);
    select();
    apply_stimulus("t6a", 8'h5A, 8'hC3);
    rx_read();
    apply_stimulus("t6b", 8'hA5, 8'h00);
    deselect();
    check_output("t6.overrun", 32'(bus.overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
